// File: rtl/mask_filter.sv
// ---------------------------------------------------------------------------
// mask_filter
//   Streaming 3x3 mask filter over a raster-order pixel stream. Two image
//   lines plus three pixels are held in a shift register. The 3x3
//   neighbourhood of the output position is read from that register. The
//   filter (max / min / Gaussian / bypass) is chosen once per frame. Border
//   positions always pass the centre pixel through unchanged. After the last
//   pixel of a frame, the block drains the final IMG_W+1 outputs while
//   holding busy high.
//
// Parameters
//   DATA_W  pixel width in bits
//   IMG_W   image width in pixels  (>= 3)
//   IMG_H   image height in pixels (>= 3)
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous reset, active low
//   data_in    input pixel, raster order
//   in_valid   data_in valid this cycle (ignored while busy)
//   mode       filter select: 0 max, 1 min, 2 Gaussian, 3 bypass
//   data_out   filtered pixel (registered, holds between outputs)
//   out_valid  data_out valid this cycle (registered)
//   busy       block refuses input this cycle (registered, high in FLUSH)
// ---------------------------------------------------------------------------
module mask_filter #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              busy
);

  localparam int NPIX = IMG_W * IMG_H;
  // The 2*IMG_W+3-entry window is the incoming pixel plus 2*IMG_W+2 stored
  // pixels. Entry 0 of the window is the pixel being shifted in this cycle.
  localparam int SR_N = 2 * IMG_W + 2;
  localparam int PW   = $clog2(NPIX);
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);
  localparam int FW   = $clog2(IMG_W + 1);
  localparam int GW   = DATA_W + 4;

  localparam logic [1:0] M_MAX   = 2'd0;
  localparam logic [1:0] M_MIN   = 2'd1;
  localparam logic [1:0] M_GAUSS = 2'd2;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_in_cnt;   // pixels accepted in this frame
  logic [RW-1:0]     r_orow;     // row of the next output position
  logic [CW-1:0]     r_ocol;     // column of the next output position
  logic [FW-1:0]     r_fcnt;     // flush outputs emitted so far
  logic [1:0]        r_mode;     // filter latched at pixel 0
  logic [DATA_W-1:0] r_sr [SR_N];

  logic              w_acc;
  logic              w_flush;
  logic              w_shift;
  logic              w_emit;
  logic              w_border;
  logic [DATA_W-1:0] w_nxt [SR_N+1];
  logic [DATA_W-1:0] w_win [9];
  logic [DATA_W-1:0] w_max;
  logic [DATA_W-1:0] w_min;
  logic [GW-1:0]     w_gsum;
  logic [DATA_W-1:0] w_gauss;
  logic [DATA_W-1:0] w_res;

  // busy is high exactly while in FLUSH. Gating with it keeps X on
  // in_valid from leaking into state during the drain.
  assign w_acc   = in_valid && !busy;
  assign w_flush = (r_state == S_FLUSH);
  assign w_shift = w_acc || w_flush;
  assign w_emit  = ((r_state == S_RUN) && w_acc) || w_flush;

  // Post-shift view of the register. Filtering this view lets the result
  // be registered on the same edge that shifts the pixel in.
  always_comb begin
    w_nxt[0] = w_flush ? '0 : data_in;
    for (int j = 1; j <= SR_N; j++) w_nxt[j] = r_sr[j-1];
  end

  // After the shift, entry IMG_W+1 is the centre. A neighbour at raster
  // offset d from the centre sits at entry IMG_W+1-d.
  always_comb begin
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w_win[rr*3+cc] = w_nxt[(2-rr)*IMG_W + (2-cc)];
  end

  always_comb begin
    w_max = w_win[0];
    w_min = w_win[0];
    for (int i = 1; i < 9; i++) begin
      if (w_win[i] > w_max) w_max = w_win[i];
      if (w_win[i] < w_min) w_min = w_win[i];
    end
  end

  // Gaussian weights are 1/2/4, so each tap is a shift. Shift by 1 for the
  // middle row, 1 for the middle column, and 2 for the centre.
  always_comb begin
    w_gsum = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++)
        w_gsum = w_gsum + (GW'(w_win[rr*3+cc]) << ((rr == 1 ? 1 : 0) + (cc == 1 ? 1 : 0)));
  end

  // The sum is at most 16*(2^DATA_W-1). Adding 8 still fits in GW bits,
  // and the rounded quotient fits in DATA_W.
  assign w_gauss = DATA_W'((w_gsum + GW'(8)) >> 4);

  assign w_border = (r_orow == '0) || (r_orow == RW'(IMG_H-1)) ||
                    (r_ocol == '0) || (r_ocol == CW'(IMG_W-1));

  always_comb begin
    w_res = w_win[4];
    if (!w_border) begin
      case (r_mode)
        M_MAX:   w_res = w_max;
        M_MIN:   w_res = w_min;
        M_GAUSS: w_res = w_gauss;
        default: w_res = w_win[4];
      endcase
    end
  end

  // Line buffers / window. Zeros enter during flush. They only ever reach
  // border outputs, which use the centre pixel alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < SR_N; j++) r_sr[j] <= '0;
    end else if (w_shift) begin
      for (int j = 0; j < SR_N; j++) r_sr[j] <= w_nxt[j];
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FILL;
      r_in_cnt  <= '0;
      r_orow    <= '0;
      r_ocol    <= '0;
      r_fcnt    <= '0;
      r_mode    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      if (w_emit) begin
        data_out  <= w_res;
        out_valid <= 1'b1;
        if (r_ocol == CW'(IMG_W-1)) begin
          r_ocol <= '0;
          r_orow <= r_orow + RW'(1);
        end else begin
          r_ocol <= r_ocol + CW'(1);
        end
      end

      case (r_state)
        S_FILL: begin
          if (w_acc) begin
            if (r_in_cnt == '0) r_mode <= mode;
            r_in_cnt <= r_in_cnt + PW'(1);
            if (r_in_cnt == PW'(IMG_W)) r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_acc) begin
            if (r_in_cnt == PW'(NPIX-1)) begin
              r_state  <= S_FLUSH;
              r_in_cnt <= '0;
              r_fcnt   <= '0;
              busy     <= 1'b1;
            end else begin
              r_in_cnt <= r_in_cnt + PW'(1);
            end
          end
        end
        S_FLUSH: begin
          if (r_fcnt == FW'(IMG_W)) begin
            // This edge emits the last output of the frame. Its row/col
            // advance is overridden here, so the next frame starts at 0,0.
            r_state <= S_FILL;
            r_orow  <= '0;
            r_ocol  <= '0;
            busy    <= 1'b0;
          end else begin
            r_fcnt <= r_fcnt + FW'(1);
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_filter.sv
// ---------------------------------------------------------------------------
// tb_mask_filter
//   Directed bench for mask_filter. Two instances share the clock and reset:
//   u_dut uses the default 8-bit 16x16 parameters, and u_dut_s uses 10-bit
//   5x4. Expected outputs are written as closed-form, hand-derived formulas
//   for each stimulus pattern (constant, impulse, ramp, bypass).
// ---------------------------------------------------------------------------
module tb_mask_filter;

  localparam int K_CONST = 0;
  localparam int K_IMP   = 1;
  localparam int K_RMIN  = 2;
  localparam int K_RMAX  = 3;
  localparam int K_LATCH = 4;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [7:0] a_din, a_dout;
  logic       a_vld, a_ov, a_busy;
  logic [1:0] a_mode;

  logic [9:0] b_din, b_dout;
  logic       b_vld, b_ov, b_busy;
  logic [1:0] b_mode;

  int n_chk  = 0;
  int n_fail = 0;
  int a_q[$];
  int b_q[$];

  always #5 clk = ~clk;

  mask_filter u_dut (
    .clk(clk), .rst(rst_n), .data_in(a_din), .in_valid(a_vld), .mode(a_mode),
    .data_out(a_dout), .out_valid(a_ov), .busy(a_busy)
  );

  mask_filter #(.DATA_W(10), .IMG_W(5), .IMG_H(4)) u_dut_s (
    .clk(clk), .rst(rst_n), .data_in(b_din), .in_valid(b_vld), .mode(b_mode),
    .data_out(b_dout), .out_valid(b_ov), .busy(b_busy)
  );

  always @(negedge clk) begin
    if (a_ov) a_q.push_back(int'(a_dout));
    if (b_ov) b_q.push_back(int'(b_dout));
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit ov(input bit sel);
    return sel ? b_ov : a_ov;
  endfunction

  function automatic bit bsy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  task automatic drive(input bit sel, input logic [15:0] d, input logic v, input logic [1:0] m);
    if (sel) begin b_din = d[9:0]; b_vld = v; b_mode = m; end
    else     begin a_din = d[7:0]; a_vld = v; a_mode = m; end
  endtask

  function automatic int pix(input bit sel, input int kind, input int k);
    case (kind)
      K_CONST: return sel ? 'h3A5 : 'h80;
      K_IMP:   return (k == (sel ? 7 : 85)) ? (sel ? 'h3FF : 'hFF) : 0;
      default: return k;
    endcase
  endfunction

  // Impulse at (5,5) for 16x16, and at (1,2) for 5x4.
  // Gaussian of an impulse v: centre (4v+8)>>4, edge (2v+8)>>4, corner (v+8)>>4.
  function automatic int expv(input bit sel, input int kind, input int k);
    int w, h, r, c, dr, dc;
    bit bord;
    w = sel ? 5 : 16;
    h = sel ? 4 : 16;
    r = k / w;
    c = k % w;
    bord = (r == 0) || (r == h-1) || (c == 0) || (c == w-1);
    case (kind)
      K_CONST: return pix(sel, kind, k);
      K_IMP: begin
        if (bord) return pix(sel, kind, k);
        dr = r - (sel ? 1 : 5); if (dr < 0) dr = -dr;
        dc = c - (sel ? 2 : 5); if (dc < 0) dc = -dc;
        if (dr == 0 && dc == 0) return sel ? 256 : 'h40;
        if (dr + dc == 1)       return sel ? 128 : 'h20;
        if (dr == 1 && dc == 1) return sel ? 64  : 'h10;
        return 0;
      end
      K_RMIN:  return bord ? k : k - w - 1;
      K_RMAX:  return bord ? k : k + w + 1;
      default: return k;
    endcase
  endfunction

  task automatic wait_idle(input bit sel);
    int t = 0;
    while (bsy(sel) && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) check("idle_timeout", 1, 0);
  endtask

  task automatic run_frame(input bit sel, input int kind, input logic [1:0] md,
                           input bit gaps, input bit lat);
    int w, n, nb, nov, bub_err, bsy_err, qn, got;
    w = sel ? 5 : 16;
    n = w * (sel ? 4 : 16);
    wait_idle(sel);
    if (sel) b_q.delete(); else a_q.delete();
    bub_err = 0;
    bsy_err = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        drive(sel, 16'h00AA, 1'b0, md);
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          if (ov(sel)) bub_err++;
        end
      end
      if (bsy(sel)) bsy_err++;
      drive(sel, 16'(pix(sel, kind, k)), 1'b1, (kind == K_LATCH && k >= 50) ? 2'd2 : md);
      @(posedge clk); #1;
      if (lat && k == w)     check("no_out_in_fill", int'(ov(sel)), 0);
      if (lat && k == w + 1) check("first_out", int'(ov(sel)), 1);
    end
    // Junk offered during the drain must be ignored.
    drive(sel, 16'h0155, 1'b1, 2'd0);
    check("busy_rise", int'(bsy(sel)), 1);
    nb = 0;
    nov = 0;
    while (bsy(sel) && nb < 100) begin
      nb++;
      if (!ov(sel)) nov++;
      @(posedge clk); #1;
    end
    drive(sel, 16'h0000, 1'b0, md);
    check("busy_cycles", nb, w + 1);
    check("ov_in_flush", nov, 0);
    repeat (2) begin @(posedge clk); #1; end
    if (gaps) check("bubble_out", bub_err, 0);
    check("busy_in_frame", bsy_err, 0);
    qn = sel ? b_q.size() : a_q.size();
    check("out_count", qn, n);
    for (int i = 0; i < qn && i < n; i++) begin
      got = sel ? b_q[i] : a_q[i];
      check($sformatf("%s_k%0d_px%0d", sel ? "s" : "a", kind, i), got, expv(sel, kind, i));
    end
  endtask

  task automatic reset_mid();
    int n;
    wait_idle(0);
    for (int k = 0; k <= 100; k++) begin
      drive(0, 16'(k), 1'b1, 2'd1);
      @(posedge clk); #1;
    end
    drive(0, 16'd101, 1'b1, 2'd1);
    check("pre_rst_ov", int'(a_ov), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_dout", int'(a_dout), 0);
    check("rst_async_ov", int'(a_ov), 0);
    check("rst_async_busy", int'(a_busy), 0);
    @(posedge clk); #1;
    check("rst_hold_dout", int'(a_dout), 0);
    check("rst_hold_ov", int'(a_ov), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 16'h0000, 1'b0, 2'd1);
    n = 0;
    repeat (3) begin @(posedge clk); #1; if (a_ov) n++; end
    check("no_stale_out", n, 0);
    run_frame(0, K_RMIN, 2'd1, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 16'h0000, 1'b0, 2'd0);
    drive(1, 16'h0000, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", int'(a_dout), 0);
    check("reset_ov", int'(a_ov), 0);
    check("reset_busy", int'(a_busy), 0);
    check("reset_s_busy", int'(b_busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, K_CONST, 2'd0, 1'b0, 1'b1);
    run_frame(0, K_IMP,   2'd2, 1'b0, 1'b0);
    run_frame(0, K_RMIN,  2'd1, 1'b0, 1'b0);
    run_frame(0, K_RMAX,  2'd0, 1'b0, 1'b0);
    run_frame(0, K_RMIN,  2'd1, 1'b1, 1'b0);
    reset_mid();
    run_frame(0, K_LATCH, 2'd3, 1'b0, 1'b0);
    run_frame(1, K_CONST, 2'd0, 1'b0, 1'b1);
    run_frame(1, K_IMP,   2'd2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
